// File: rtl/alert_qual_if.sv
// alert_qual_if: sample feed into the alert qualifier and the qualified alert
// levels back out.
//   vld       one-cycle strobe, lft_spd/rght_spd/batt valid this clk
//   lft_spd   signed left wheel speed
//   rght_spd  signed right wheel speed
//   batt      unsigned battery ADC reading
//   too_fast  qualified overspeed level
//   batt_low  qualified low-battery level (includes stale)
//   stale     sample feed watchdog expired
// master = sample source / alert consumer, slave = alert_qual.
interface alert_qual_if;
  logic        vld;
  logic [11:0] lft_spd;
  logic [11:0] rght_spd;
  logic [11:0] batt;
  logic        too_fast;
  logic        batt_low;
  logic        stale;

  modport master (output vld, lft_spd, rght_spd, batt,
                  input  too_fast, batt_low, stale);
  modport slave  (input  vld, lft_spd, rght_spd, batt,
                  output too_fast, batt_low, stale);
endinterface

// File: rtl/alert_qual.sv
// alert_qual: debounces raw speed/battery samples into clean too_fast and
// batt_low levels for the piezo driver, with a dead-feed watchdog.
//   clk    system clock
//   rst_n  asynchronous active-low reset
//   bus    alert_qual_if.slave (vld, lft_spd, rght_spd, batt in;
//          too_fast, batt_low, stale out)
// Build option: ALERT_LATCH_EN - when defined, batt_low latches once qualified
// and only rst_n releases it (stale is still OR'd in).

// Generic qualifier: N consecutive asserting samples raise lvl, M consecutive
// deasserting samples drop it. Samples that are neither (hysteresis band)
// restart a pending count without moving the level.
module alert_qual_fsm #(
  parameter int ASSERT_CNT   = 4,
  parameter int DEASSERT_CNT = 8,
  parameter bit LATCH        = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic vld,
  input  logic asrt,
  input  logic dsrt,
  output logic lvl
);
  typedef enum logic [1:0] {OK, PEND_HI, ALERT, PEND_LO} state_t;

  localparam logic [3:0] A_N = 4'(ASSERT_CNT);
  localparam logic [3:0] D_N = 4'(DEASSERT_CNT);

  state_t     st;
  logic [3:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st  <= OK;
      cnt <= 4'd0;
      lvl <= 1'b0;
    end else if (vld) begin
      case (st)
        OK: if (asrt) begin
          if (A_N == 4'd1) begin
            st  <= ALERT;
            lvl <= 1'b1;
            cnt <= 4'd0;
          end else begin
            st  <= PEND_HI;
            cnt <= 4'd1;
          end
        end
        PEND_HI: if (asrt) begin
          if (cnt + 4'd1 == A_N) begin
            st  <= ALERT;
            lvl <= 1'b1;
            cnt <= 4'd0;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end else begin
          st  <= OK;
          cnt <= 4'd0;
        end
        ALERT: if (dsrt && !LATCH) begin
          if (D_N == 4'd1) begin
            st  <= OK;
            lvl <= 1'b0;
            cnt <= 4'd0;
          end else begin
            st  <= PEND_LO;
            cnt <= 4'd1;
          end
        end
        PEND_LO: if (dsrt) begin
          if (cnt + 4'd1 == D_N) begin
            st  <= OK;
            lvl <= 1'b0;
            cnt <= 4'd0;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end else begin
          st  <= ALERT;
          cnt <= 4'd0;
        end
        default: begin
          st  <= OK;
          cnt <= 4'd0;
          lvl <= 1'b0;
        end
      endcase
    end
  end
endmodule

module alert_qual #(
  parameter logic [11:0] SPD_THRESH   = 12'd1536,
  parameter logic [11:0] SPD_HYST     = 12'd128,
  parameter logic [11:0] BATT_THRESH  = 12'hA98,
  parameter logic [11:0] BATT_HYST    = 12'h040,
  parameter int          ASSERT_CNT   = 4,
  parameter int          DEASSERT_CNT = 8,
  parameter bit          fast_sim     = 1'b0
) (
  input logic         clk,
  input logic         rst_n,
  alert_qual_if.slave bus
);
  generate
    if (SPD_HYST > SPD_THRESH)
      $error("alert_qual: SPD_HYST must not exceed SPD_THRESH");
    if (ASSERT_CNT < 1 || ASSERT_CNT > 15 || DEASSERT_CNT < 1 || DEASSERT_CNT > 15)
      $error("alert_qual: ASSERT_CNT/DEASSERT_CNT must be 1..15");
  endgenerate

  localparam logic [11:0] SPD_LO  = SPD_THRESH - SPD_HYST;
  localparam logic [12:0] BATT_SUM = {1'b0, BATT_THRESH} + {1'b0, BATT_HYST};
  localparam logic [11:0] BATT_HI = BATT_SUM[12] ? 12'hFFF : BATT_SUM[11:0];
  localparam logic [24:0] WD_LAST = fast_sim ? 25'((1 << 16) - 1) : 25'((1 << 24) - 1);

`ifdef ALERT_LATCH_EN
  localparam bit BATT_LATCH = 1'b1;
`else
  localparam bit BATT_LATCH = 1'b0;
`endif

  // |v| as unsigned; -2048 has no positive twin and saturates to 2047.
  function automatic logic [11:0] abs12(input logic [11:0] v);
    if (v == 12'h800)  return 12'h7FF;
    else if (v[11])    return ~v + 12'd1;
    else               return v;
  endfunction

  logic [11:0] lft_mag, rght_mag, mag;
  assign lft_mag  = abs12(bus.lft_spd);
  assign rght_mag = abs12(bus.rght_spd);
  assign mag      = (lft_mag > rght_mag) ? lft_mag : rght_mag;

  logic spd_lvl, batt_lvl;

  alert_qual_fsm #(.ASSERT_CNT(ASSERT_CNT), .DEASSERT_CNT(DEASSERT_CNT), .LATCH(1'b0))
    u_spd (
      .clk  (clk),
      .rst_n(rst_n),
      .vld  (bus.vld),
      .asrt (mag > SPD_THRESH),
      .dsrt (mag < SPD_LO),
      .lvl  (spd_lvl)
    );

  alert_qual_fsm #(.ASSERT_CNT(ASSERT_CNT), .DEASSERT_CNT(DEASSERT_CNT), .LATCH(BATT_LATCH))
    u_batt (
      .clk  (clk),
      .rst_n(rst_n),
      .vld  (bus.vld),
      .asrt (bus.batt < BATT_THRESH),
      .dsrt (bus.batt >= BATT_HI),
      .lvl  (batt_lvl)
    );

  // Watchdog: counts idle cycles, saturates at expiry. vld always wins.
  logic [24:0] wd;
  logic        stale_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wd      <= 25'd0;
      stale_q <= 1'b0;
    end else if (bus.vld) begin
      wd      <= 25'd0;
      stale_q <= 1'b0;
    end else if (!stale_q) begin
      wd <= wd + 25'd1;
      if (wd == WD_LAST) stale_q <= 1'b1;
    end
  end

  assign bus.too_fast = spd_lvl;
  assign bus.stale    = stale_q;
  assign bus.batt_low = batt_lvl | stale_q;
endmodule
